// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states,
// access owners, LSB size codes and the default I/O address window.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RD   = 2'd1,
    MC_WR   = 2'd2
  } mc_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSB = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] IO_ADDR_HI_DEF = 2'b11;

  // Size code 11 is treated as a word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO port arbiter between instruction fetch and the LSB:
// round-robin grant, little-endian assembly, flush abort of reads.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEF
) (
  input  logic        clk,
  input  logic        rst_in_n,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mc_state_e   state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_q, last_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] asm_q, asm_d;
  logic        if_done_q, if_done_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] lsb_data_q, lsb_data_d;

  logic        if_elig, lsb_elig, pick_lsb, io_stall;
  logic [1:0]  cap_idx;
  logic [31:0] asm_cap, byte_addr;

  assign if_elig   = if_req  && !if_done_q  && !flush;
  assign lsb_elig  = lsb_req && !lsb_done_q && !flush;
  assign pick_lsb  = lsb_elig && (!if_elig || last_q == OWN_IF);
  assign io_stall  = (base_q[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign byte_addr = base_q + {29'd0, cnt_q};

  // One-cycle RAM latency: at cnt=k the byte on mem_din belongs to address k-1.
  assign cap_idx = cnt_q[1:0] - 2'd1;
  always_comb begin
    asm_cap = asm_q;
    asm_cap[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    asm_d      = asm_q;
    if_done_d  = if_done_q;
    lsb_done_d = lsb_done_q;
    if_data_d  = if_data_q;
    lsb_data_d = lsb_data_q;
    if (rdy_in) begin
      if_done_d  = 1'b0;
      lsb_done_d = 1'b0;
      unique case (state_q)
        MC_IDLE: begin
          if (if_elig || lsb_elig) begin
            owner_d = pick_lsb ? OWN_LSB : OWN_IF;
            last_d  = pick_lsb ? OWN_LSB : OWN_IF;
            base_d  = pick_lsb ? lsb_addr : if_addr;
            n_d     = pick_lsb ? byte_count(lsb_size) : 3'd4;
            cnt_d   = '0;
            asm_d   = '0;
            state_d = (pick_lsb && lsb_wr) ? MC_WR : MC_RD;
          end
        end
        MC_RD: begin
          if (flush) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
          end else begin
            if (cnt_q != 3'd0) asm_d = asm_cap;
            if (cnt_q == n_q) begin
              state_d = MC_IDLE;
              if (owner_q == OWN_LSB) begin
                lsb_done_d = 1'b1;
                lsb_data_d = asm_cap;
              end else begin
                if_done_d = 1'b1;
                if_data_d = asm_cap;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        MC_WR: begin
          if (!io_stall) begin
            if (cnt_q == n_q - 3'd1) begin
              lsb_done_d = 1'b1;
              state_d    = MC_IDLE;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: state_d = MC_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (state_q == MC_RD && cnt_q != n_q) begin
      mem_a = byte_addr;
    end else if (state_q == MC_WR) begin
      mem_a    = byte_addr;
      mem_dout = lsb_wdata[{cnt_q[1:0], 3'b000} +: 8];
      mem_wr   = rdy_in && !io_stall;
    end
  end

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q    <= MC_IDLE;
      owner_q    <= OWN_IF;
      last_q     <= OWN_LSB;
      base_q     <= '0;
      cnt_q      <= '0;
      n_q        <= '0;
      asm_q      <= '0;
      if_done_q  <= 1'b0;
      lsb_done_q <= 1'b0;
      if_data_q  <= '0;
      lsb_data_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      asm_q      <= asm_d;
      if_done_q  <= if_done_d;
      lsb_done_q <= lsb_done_d;
      if_data_q  <= if_data_d;
      lsb_data_q <= lsb_data_d;
    end
  end

  assign if_done  = if_done_q;
  assign lsb_done = lsb_done_q;
  assign if_data  = if_data_q;
  assign lsb_data = lsb_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: RAM model with one-cycle read latency,
// scoreboards for fetch data, LSB completions and issued write bytes.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_in_n = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [1:0]  lsb_size = '0;
  logic [31:0] lsb_wdata = '0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = '0;
  logic        if_done, lsb_done, mem_wr;
  logic [31:0] if_data, lsb_data, mem_a;
  logic [7:0]  mem_dout;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } lsb_exp_t;

  logic [7:0]  ram [0:65535];
  logic [31:0] if_q[$];
  lsb_exp_t    lsb_q[$];
  logic [39:0] wr_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          if_pulses = 0;
  int          lsb_pulses = 0;

  mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (
    .clk(clk), .rst_in_n(rst_in_n), .rdy_in(rdy_in), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_data(lsb_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_din <= ram[mem_a[15:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input logic cond);
    n_checks++;
    assert (cond === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected 1", tag, cond);
    end
  endtask

  // Start of a new cycle: inputs change just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Returns at the mid-cycle sample point of the first done cycle.
  task automatic wait_done(input string tag, input bit want_lsb);
    int unsigned k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(if_done || lsb_done) && k < 40);
    check(tag, {30'd0, if_done, lsb_done}, want_lsb ? 32'd1 : 32'd2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_a"}, mem_a, 32'd0);
    check({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
    check({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
    check({tag, "_if_done"}, {31'd0, if_done}, 32'd0);
    check({tag, "_lsb_done"}, {31'd0, lsb_done}, 32'd0);
    check({tag, "_if_data"}, if_data, 32'd0);
    check({tag, "_lsb_data"}, lsb_data, 32'd0);
  endtask

  always @(negedge clk) begin : monitor
    lsb_exp_t le;
    logic [39:0] we;
    if (if_done || lsb_done) check("one_done", {31'd0, if_done && lsb_done}, 32'd0);
    if (if_done) begin
      if_pulses++;
      check_true("if_done_expected", if_q.size() != 0);
      if (if_q.size() != 0) check("if_data", if_data, if_q.pop_front());
    end
    if (lsb_done) begin
      lsb_pulses++;
      check_true("lsb_done_expected", lsb_q.size() != 0);
      if (lsb_q.size() != 0) begin
        le = lsb_q.pop_front();
        if (le.chk) check("lsb_data", lsb_data, le.data);
      end
    end
    if (mem_wr) begin
      check_true("write_expected", wr_q.size() != 0);
      if (wr_q.size() != 0) begin
        we = wr_q.pop_front();
        check("wr_addr", mem_a, we[39:8]);
        check("wr_data", {24'd0, mem_dout}, {24'd0, we[7:0]});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base_cnt;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h5A;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
    ram[16'h0200] = 8'h11; ram[16'h0201] = 8'h22; ram[16'h0202] = 8'h33; ram[16'h0203] = 8'h44;
    ram[16'h0300] = 8'hDE; ram[16'h0301] = 8'hAD; ram[16'h0302] = 8'hBE; ram[16'h0303] = 8'hEF;
    ram[16'hFFFE] = 8'hA1; ram[16'hFFFF] = 8'hB2; ram[16'h0000] = 8'hC3; ram[16'h0001] = 8'hD4;

    @(negedge clk);
    check_reset_outputs("reset");
    cyc();
    rst_in_n = 1'b1;

    // Simultaneous requests after reset: IF, LSB, IF.
    cyc();
    if_req = 1'b1; if_addr = 32'h200;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = SZ_W_TB(); lsb_addr = 32'h300;
    if_q.push_back(32'h44332211);
    lsb_q.push_back('{chk: 1'b1, data: 32'hEFBEADDE});
    if_q.push_back(32'h44332211);
    wait_done("rr_first_if", 1'b0);
    wait_done("rr_then_lsb", 1'b1);
    cyc();
    lsb_req = 1'b0;
    wait_done("rr_then_if", 1'b0);
    cyc();
    if_req = 1'b0;

    // Fetch-only word read with exact address sequence and done latency.
    cyc();
    if_req = 1'b1; if_addr = 32'h100;
    if_q.push_back(32'h00000513);
    @(negedge clk);
    check("fetch_idle_addr", mem_a, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fetch_addr", mem_a, 32'h100 + i);
    end
    @(negedge clk);
    check("fetch_last_addr", mem_a, 32'd0);
    @(negedge clk);
    check("fetch_done_cycle", {31'd0, if_done}, 32'd1);
    cyc();
    if_req = 1'b0;

    // Half store to the I/O window with two full-buffer stall cycles.
    cyc();
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b01; lsb_addr = 32'h30000;
    lsb_wdata = 32'h0000ABCD; io_buffer_full = 1'b1;
    wr_q.push_back({32'h30000, 8'hCD});
    wr_q.push_back({32'h30001, 8'hAB});
    lsb_q.push_back('{chk: 1'b0, data: 32'd0});
    @(negedge clk);
    @(negedge clk);
    check("io_stall1", {31'd0, mem_wr}, 32'd0);
    check("io_stall_addr", mem_a, 32'h30000);
    @(negedge clk);
    check("io_stall2", {31'd0, mem_wr}, 32'd0);
    cyc();
    io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_byte0_wr", {31'd0, mem_wr}, 32'd1);
    @(negedge clk);
    check("io_byte1_addr", mem_a, 32'h30001);
    @(negedge clk);
    check("io_store_done", {31'd0, lsb_done}, 32'd1);
    cyc();
    lsb_req = 1'b0; lsb_wr = 1'b0;

    // Flush during the second byte of a fetch aborts it silently.
    cyc();
    base_cnt = if_pulses;
    if_req = 1'b1; if_addr = 32'h100;
    cyc();
    cyc();
    flush = 1'b1;
    @(negedge clk);
    check("flush_2nd_byte_addr", mem_a, 32'h101);
    cyc();
    @(negedge clk);
    check("flush_idle_addr", mem_a, 32'd0);
    cyc();
    flush = 1'b0; if_req = 1'b0;
    repeat (8) @(negedge clk);
    check("flush_no_if_done", 32'(if_pulses), 32'(base_cnt));
    cyc();
    if_req = 1'b1; if_addr = 32'h200;
    if_q.push_back(32'h44332211);
    wait_done("after_flush_fetch", 1'b0);
    cyc();
    if_req = 1'b0;

    // Flush during a word store does not stop it.
    cyc();
    base_cnt = lsb_pulses;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h400;
    lsb_wdata = 32'h87654321;
    wr_q.push_back({32'h400, 8'h21});
    wr_q.push_back({32'h401, 8'h43});
    wr_q.push_back({32'h402, 8'h65});
    wr_q.push_back({32'h403, 8'h87});
    lsb_q.push_back('{chk: 1'b0, data: 32'd0});
    cyc();
    cyc();
    flush = 1'b1;
    wait_done("flush_store_done", 1'b1);
    cyc();
    lsb_req = 1'b0; lsb_wr = 1'b0; flush = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_store_one_pulse", 32'(lsb_pulses), 32'(base_cnt + 1));

    // Loads of each size, zero-extended.
    for (int i = 0; i < 3; i++) begin
      cyc();
      lsb_req = 1'b1; lsb_wr = 1'b0;
      case (i)
        0: begin lsb_size = 2'b00; lsb_addr = 32'h201; lsb_q.push_back('{chk: 1'b1, data: 32'h00000022}); end
        1: begin lsb_size = 2'b01; lsb_addr = 32'h202; lsb_q.push_back('{chk: 1'b1, data: 32'h00004433}); end
        default: begin lsb_size = 2'b11; lsb_addr = 32'h300; lsb_q.push_back('{chk: 1'b1, data: 32'hEFBEADDE}); end
      endcase
      wait_done("load_done", 1'b1);
      cyc();
      lsb_req = 1'b0;
    end

    // Address wrap past 0xFFFFFFFF with a two-cycle rdy_in freeze.
    cyc();
    if_req = 1'b1; if_addr = 32'hFFFFFFFE;
    if_q.push_back(32'hD4C3B2A1);
    cyc();
    rdy_in = 1'b0;
    cyc();
    @(negedge clk);
    check("freeze_addr", mem_a, 32'hFFFFFFFE);
    check("freeze_no_wr", {31'd0, mem_wr}, 32'd0);
    cyc();
    rdy_in = 1'b1;
    @(negedge clk);
    check("wrap_byte0", mem_a, 32'hFFFFFFFE);
    @(negedge clk);
    check("wrap_byte1", mem_a, 32'hFFFFFFFF);
    @(negedge clk);
    check("wrap_byte2", mem_a, 32'h00000000);
    wait_done("wrap_done", 1'b0);
    cyc();
    if_req = 1'b0;

    // Asynchronous reset mid-read; held request restarts from byte 0.
    cyc();
    if_req = 1'b1; if_addr = 32'h300;
    if_q.push_back(32'hEFBEADDE);
    cyc();
    cyc();
    @(negedge clk);
    check("pre_reset_addr", mem_a, 32'h301);
    cyc();
    rst_in_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    cyc();
    rst_in_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("restart_addr", mem_a, 32'h300);
    wait_done("restart_done", 1'b0);
    cyc();
    if_req = 1'b0;

    repeat (3) @(negedge clk);
    check("if_queue_empty", 32'(if_q.size()), 32'd0);
    check("lsb_queue_empty", 32'(lsb_q.size()), 32'd0);
    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [1:0] SZ_W_TB();
    return 2'b10;
  endfunction

endmodule
